// File: rtl/mac_seq_ctrl.sv
// Command-framed unsigned dot-product sequencer: pulls len operand pairs over a
// valid/ready stream, accumulates a*b modulo 2^(2*WIDTH), returns the sum on a result handshake.
module mac_seq_ctrl #(
   parameter  int WIDTH   = 8,
   parameter  int MAX_LEN = 16,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [LEN_W-1:0]     len,
   input  logic                 abort,
   output logic                 busy,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic [LEN_W-1:0]     count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       count_q;
   logic [2*WIDTH-1:0]     acc_q;
   logic [2*WIDTH-1:0]     result_q;
   logic [LEN_W-1:0]       len_clamped;
   logic [2*WIDTH-1:0]     acc_nxt;
   logic                   beat;
   logic                   last_beat;
   logic                   cmd_go;

   // Full-width unsigned product added with natural modulo wrap, no saturation.
   function automatic logic [2*WIDTH-1:0] mac_wrap(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   a,
                                                   input logic [WIDTH-1:0]   b);
      logic [2*WIDTH-1:0] prod;
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      return acc + prod;
   endfunction

   assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   assign beat        = in_valid && (state_q == RUN);
   assign last_beat   = ((count_q + LEN_W'(1)) == len_q);
   assign acc_nxt     = mac_wrap(acc_q, operand_a, operand_b);
   // abort in IDLE drops a simultaneous start
   assign cmd_go      = start && !abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cmd_go) state_d = (len_clamped == '0) ? DONE : RUN;
         RUN: begin
            if (abort)                  state_d = IDLE;
            else if (beat && last_beat) state_d = DONE;
         end
         DONE: if (abort || res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q    <= '0;
         count_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_go) begin
                  len_q   <= len_clamped;
                  count_q <= '0;
                  acc_q   <= '0;
                  if (len_clamped == '0) result_q <= '0;
               end
            end
            RUN: begin
               if (abort) begin
                  count_q <= '0;
                  acc_q   <= '0;
               end else if (beat) begin
                  count_q <= count_q + LEN_W'(1);
                  acc_q   <= acc_nxt;
                  if (last_beat) result_q <= acc_nxt;
               end
            end
            DONE: begin
               if (abort) begin
                  count_q <= '0;
                  acc_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == RUN);
   assign res_valid = (state_q == DONE);
   assign result    = result_q;
   assign count     = count_q;

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that runs one unsigned dot product of programmable length per command.
- Accepts a start command with a vector length, then pulls operand pairs over a valid/ready stream.
- Accumulates the pairs in an internal multiply-accumulate datapath and presents the final sum on a valid/ready result port.
- Sits between the operand source (buffer/DMA) and the consumer, so the MAC only ever accumulates within one framed command.

Parameters:
WIDTH, 8, operand width in bits; result and accumulator width is 2*WIDTH.
MAX_LEN, 16, maximum vector length per command.
LEN_W, $clog2(MAX_LEN+1), width of the length and count fields (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  command strobe; sampled only in IDLE.
len  input  LEN_W  vector length, latched with start; values above MAX_LEN are clamped to MAX_LEN.
abort  input  1  cancels the current command.
busy  output  1  high in any state other than IDLE.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept an operand pair.
operand_a  input  WIDTH  unsigned multiplicand.
operand_b  input  WIDTH  unsigned multiplier.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
result  output  2*WIDTH  dot-product sum.
count  output  LEN_W  number of pairs accepted in the current command.

Behaviour:
- Reset (reset_n low, at any time, including mid-command): state goes to IDLE asynchronously. busy=0, in_ready=0, res_valid=0, result=0, count=0, accumulator=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0, res_valid=0.
  - start=1 with len>0: latch len, clear accumulator and count, enter RUN next cycle.
  - start=1 with len==0: clear accumulator, enter DONE next cycle with result=0.
- RUN:
  - in_ready=1 combinationally from state.
  - A beat transfers when in_valid && in_ready. On a transfer, accumulator <= accumulator + operand_a*operand_b and count <= count+1.
  - The product is a full 2*WIDTH unsigned product. The sum wraps modulo 2^(2*WIDTH); there is no saturation and no overflow flag.
  - Cycles with in_valid=0 hold all state.
  - On the transfer that makes count == latched len: enter DONE next cycle, with result = final accumulator (including that beat).
  - Latency is 1 cycle from the last accepted beat to res_valid=1.
  - in_ready deasserts in DONE, so no extra beat is consumed.
- DONE:
  - res_valid=1, in_ready=0.
  - result and count are held stable until the handshake completes.
  - On res_valid && res_ready: return to IDLE next cycle. result keeps its last value in IDLE; res_valid drops.
- start while busy=1 is ignored; there is no queuing.
- abort:
  - In RUN or DONE, abort=1 forces IDLE next cycle and clears the accumulator and count. No result is produced.
  - abort has priority over a simultaneous beat transfer or res_ready.
  - abort in IDLE has no effect and takes priority over a simultaneous start (the command is dropped).
- busy = (state != IDLE).
- All outputs are registered or decoded directly from state; there are no combinational paths from in_valid/res_ready to outputs.

Test Plan:
- Basic: WIDTH=8, start with len=3, pairs (2,3),(15,1),(2,2) streamed back-to-back -> result=25 (0x0019), res_valid 1 cycle after third beat, count=3, in_ready low in DONE.
- Source gaps and result backpressure: same vectors with in_valid low 2 cycles between beats, res_ready held low 5 cycles -> result stays 25 and res_valid stays high for all 5 cycles; a start pulse during DONE is ignored (busy stays 1); IDLE reached the cycle after res_ready=1.
- Wrap and clamp: len=2, pairs (255,255),(255,255) -> result=64514 (130050 mod 65536); len=20 with MAX_LEN=16 -> exactly 16 beats accepted and count=16.
- Zero length: start with len=0 -> DONE next cycle with result=0 and count=0; in_ready never asserts.
- Abort: len=4, abort asserted together with the 2nd beat -> IDLE next cycle, no res_valid; a new command len=1 with (3,5) -> result=15 (no residue from the aborted run).
- Async reset mid-RUN: reset_n pulled low between clock edges after 2 beats -> busy, in_ready, res_valid, count, result all 0 immediately; after release, len=1 with (4,4) -> result=16.
